// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low patterns {CG..CA} for hex digits and their decode.
// Meant to be reused by the driver-side encoder as well as the capture monitor.
package seg7_pkg;

  typedef logic [6:0] seg_pattern_t;
  typedef logic [3:0] nibble_t;

  localparam seg_pattern_t SEG_0 = 7'h40;
  localparam seg_pattern_t SEG_1 = 7'h79;
  localparam seg_pattern_t SEG_2 = 7'h24;
  localparam seg_pattern_t SEG_3 = 7'h30;
  localparam seg_pattern_t SEG_4 = 7'h19;
  localparam seg_pattern_t SEG_5 = 7'h12;
  localparam seg_pattern_t SEG_6 = 7'h02;
  localparam seg_pattern_t SEG_7 = 7'h78;
  localparam seg_pattern_t SEG_8 = 7'h00;
  localparam seg_pattern_t SEG_9 = 7'h10;
  localparam seg_pattern_t SEG_A = 7'h08;
  localparam seg_pattern_t SEG_B = 7'h03;
  localparam seg_pattern_t SEG_C = 7'h46;
  localparam seg_pattern_t SEG_D = 7'h21;
  localparam seg_pattern_t SEG_E = 7'h06;
  localparam seg_pattern_t SEG_F = 7'h0E;

  // Returns {err, nibble}; unknown patterns decode as nibble 0 with err set.
  function automatic logic [4:0] seg7_decode(input seg_pattern_t p);
    logic [4:0] r;
    r = 5'h10;
    case (p)
      SEG_0: r = 5'h00;
      SEG_1: r = 5'h01;
      SEG_2: r = 5'h02;
      SEG_3: r = 5'h03;
      SEG_4: r = 5'h04;
      SEG_5: r = 5'h05;
      SEG_6: r = 5'h06;
      SEG_7: r = 5'h07;
      SEG_8: r = 5'h08;
      SEG_9: r = 5'h09;
      SEG_A: r = 5'h0A;
      SEG_B: r = 5'h0B;
      SEG_C: r = 5'h0C;
      SEG_D: r = 5'h0D;
      SEG_E: r = 5'h0E;
      SEG_F: r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_pattern_decoder.sv
// Combinational wrapper turning one active-low segment pattern into a hex nibble plus error flag.
module seg7_pattern_decoder
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       err
);

  always_comb begin
    {err, nibble} = seg7_decode(pattern);
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Monitors multiplexed seven-segment/anode lines and rebuilds the displayed 4-digit hex value.
// A digit is captured once per stable dwell; four captured digits form a committed frame.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CA,
  input  logic        CB,
  input  logic        CC,
  input  logic        CD,
  input  logic        CE,
  input  logic        CF,
  input  logic        CG,
  input  logic        AN1,
  input  logic        AN2,
  input  logic        AN3,
  input  logic        AN4,
  output logic [15:0] value,
  output logic        frame_valid,
  output logic [3:0]  digit_err,
  output logic        stale
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_MAX   = SW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [3:0]    s_an_q, s_an_d, p_an_q, p_an_d;
  logic [6:0]    s_seg_q, s_seg_d, p_seg_q, p_seg_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [TW-1:0] timeout_q, timeout_d;
  logic [3:0]    mask_q, mask_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    shadow_err_q, shadow_err_d;
  logic [15:0]   value_q, value_d;
  logic [3:0]    err_q, err_d;
  logic          fv_q, fv_d;
  logic          stale_q, stale_d;

  logic [3:0] active_oh;
  logic       one_hot;
  logic       same;
  logic       capture;
  logic [3:0] cap_bit;
  logic [1:0] digit;
  logic [3:0] dec_nibble;
  logic       dec_err;

  assign active_oh = ~s_an_q;
  assign one_hot   = (active_oh != 4'b0000) && ((active_oh & (active_oh - 4'd1)) == 4'b0000);
  assign same      = (s_an_q == p_an_q) && (s_seg_q == p_seg_q);

  seg7_pattern_decoder u_dec (
    .pattern (s_seg_q),
    .nibble  (dec_nibble),
    .err     (dec_err)
  );

  always_comb begin
    digit = 2'd0;
    case (active_oh)
      4'b0010: digit = 2'd1;
      4'b0100: digit = 2'd2;
      4'b1000: digit = 2'd3;
      default: digit = 2'd0;
    endcase
  end

  always_comb begin
    s_an_d       = {AN4, AN3, AN2, AN1};
    s_seg_d      = {CG, CF, CE, CD, CC, CB, CA};
    p_an_d       = s_an_q;
    p_seg_d      = s_seg_q;
    settle_d     = '0;
    capture      = 1'b0;
    shadow_d     = shadow_q;
    shadow_err_d = shadow_err_q;
    timeout_d    = timeout_q;
    stale_d      = stale_q;
    value_d      = value_q;
    err_d        = err_q;
    fv_d         = 1'b0;

    // Capture only on the transition into SETTLE_MAX so a held dwell fires once.
    if (one_hot) begin
      if (!same) begin
        settle_d = SW'(1);
      end else if (settle_q != SETTLE_MAX) begin
        settle_d = settle_q + SW'(1);
      end else begin
        settle_d = settle_q;
      end
      capture = (settle_d == SETTLE_MAX) && !(same && (settle_q == SETTLE_MAX));
    end

    cap_bit = capture ? active_oh : 4'b0000;
    mask_d  = mask_q | cap_bit;

    if (capture) begin
      shadow_d[{digit, 2'b00} +: 4] = dec_nibble;
      shadow_err_d[digit]           = dec_err;
    end

    if (capture) begin
      timeout_d = '0;
      stale_d   = 1'b0;
    end else if (timeout_q == TIMEOUT_LAST) begin
      stale_d = 1'b1;
      mask_d  = 4'b0000;
    end else begin
      timeout_d = timeout_q + TW'(1);
    end

    // A capture on the commit edge starts the next frame.
    if (mask_q == 4'b1111) begin
      value_d = shadow_q;
      err_d   = shadow_err_q;
      fv_d    = 1'b1;
      mask_d  = cap_bit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_an_q       <= '0;
      s_seg_q      <= '0;
      p_an_q       <= '0;
      p_seg_q      <= '0;
      settle_q     <= '0;
      timeout_q    <= '0;
      mask_q       <= '0;
      shadow_q     <= '0;
      shadow_err_q <= '0;
      value_q      <= '0;
      err_q        <= '0;
      fv_q         <= 1'b0;
      stale_q      <= 1'b0;
    end else begin
      s_an_q       <= s_an_d;
      s_seg_q      <= s_seg_d;
      p_an_q       <= p_an_d;
      p_seg_q      <= p_seg_d;
      settle_q     <= settle_d;
      timeout_q    <= timeout_d;
      mask_q       <= mask_d;
      shadow_q     <= shadow_d;
      shadow_err_q <= shadow_err_d;
      value_q      <= value_d;
      err_q        <= err_d;
      fv_q         <= fv_d;
      stale_q      <= stale_d;
    end
  end

  assign value       = value_q;
  assign frame_valid = fv_q;
  assign digit_err   = err_q;
  assign stale       = stale_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Scoreboard bench for seg7_scan_capture: directed scans push expected frames, a monitor pops on frame_valid.
module tb_seg7_scan_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_lines;
  logic [3:0]  an_lines;
  logic [15:0] value;
  logic        frame_valid;
  logic [3:0]  digit_err;
  logic        stale;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  err;
  } frame_t;

  frame_t exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_scan_capture #(
    .SETTLE_CYCLES  (4),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .CA          (seg_lines[0]),
    .CB          (seg_lines[1]),
    .CC          (seg_lines[2]),
    .CD          (seg_lines[3]),
    .CE          (seg_lines[4]),
    .CF          (seg_lines[5]),
    .CG          (seg_lines[6]),
    .AN1         (an_lines[0]),
    .AN2         (an_lines[1]),
    .AN3         (an_lines[2]),
    .AN4         (an_lines[3]),
    .value       (value),
    .frame_valid (frame_valid),
    .digit_err   (digit_err),
    .stale       (stale)
  );

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h40;  4'h1: p = 7'h79;  4'h2: p = 7'h24;  4'h3: p = 7'h30;
      4'h4: p = 7'h19;  4'h5: p = 7'h12;  4'h6: p = 7'h02;  4'h7: p = 7'h78;
      4'h8: p = 7'h00;  4'h9: p = 7'h10;  4'hA: p = 7'h08;  4'hB: p = 7'h03;
      4'hC: p = 7'h46;  4'hD: p = 7'h21;  4'hE: p = 7'h06;  default: p = 7'h0E;
    endcase
    return p;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Holds one anode/segment combination for a number of rising edges.
  task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg, input int cycles);
    an_lines  = an;
    seg_lines = seg;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic blank(input int cycles);
    applyStimulus(4'hF, 7'h7F, cycles);
  endtask

  task automatic scan(input logic [15:0] v, input int dwell, input bit rev);
    for (int i = 0; i < 4; i++) begin
      int d;
      logic [3:0] an;
      d  = rev ? 3 - i : i;
      an = 4'b0001 << d;
      applyStimulus(~an, seg_of(v[4*d +: 4]), dwell);
    end
  endtask

  always @(negedge clk) begin
    frame_t e;
    if (reset && frame_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_frame: got value %0h err %0b, expected no frame at %0t",
                 value, digit_err, $time);
      end else begin
        e = exp_q.pop_front();
        checkOutput("frame_value", {16'h0, value}, {16'h0, e.value});
        checkOutput("frame_err", {28'h0, digit_err}, {28'h0, e.err});
      end
    end
  end

  initial begin
    reset     = 1'b0;
    an_lines  = 4'hF;
    seg_lines = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_value", {16'h0, value}, 32'h0);
    checkOutput("reset_fv", {31'h0, frame_valid}, 32'h0);
    checkOutput("reset_err", {28'h0, digit_err}, 32'h0);
    checkOutput("reset_stale", {31'h0, stale}, 32'h0);
    reset = 1'b1;
    blank(5);

    $display("[TB] scan 1234 with 8-cycle dwells");
    exp_q.push_back('{16'h1234, 4'b0000});
    scan(16'h1234, 8, 1'b0);
    blank(10);
    checkOutput("pending_t1", exp_q.size(), 0);

    $display("[TB] 3-cycle dwells then 4-cycle retry");
    scan(16'h1234, 3, 1'b0);
    scan(16'h1234, 3, 1'b0);
    blank(5);
    exp_q.push_back('{16'h1234, 4'b0000});
    scan(16'h1234, 4, 1'b0);
    blank(10);
    checkOutput("pending_t2", exp_q.size(), 0);

    $display("[TB] undecodable pattern on digit 2");
    exp_q.push_back('{16'h0000, 4'b0100});
    applyStimulus(4'b1110, 7'h40, 8);
    applyStimulus(4'b1101, 7'h40, 8);
    applyStimulus(4'b1011, 7'h7F, 8);
    applyStimulus(4'b0111, 7'h40, 8);
    blank(10);
    checkOutput("pending_t3", exp_q.size(), 0);

    $display("[TB] overlapping anodes then ABCD scan");
    applyStimulus(4'b1100, seg_of(4'h8), 20);
    exp_q.push_back('{16'hABCD, 4'b0000});
    scan(16'hABCD, 8, 1'b1);
    blank(10);
    checkOutput("pending_t4", exp_q.size(), 0);

    $display("[TB] partial frame then timeout");
    applyStimulus(4'b1110, seg_of(4'h1), 8);
    applyStimulus(4'b1101, seg_of(4'h2), 8);
    applyStimulus(4'b1011, seg_of(4'h3), 8);
    checkOutput("stale_before", {31'h0, stale}, 32'h0);
    blank(40);
    checkOutput("stale_early", {31'h0, stale}, 32'h0);
    blank(30);
    checkOutput("stale_set", {31'h0, stale}, 32'h1);
    checkOutput("value_kept", {16'h0, value}, 32'hABCD);
    exp_q.push_back('{16'h5678, 4'b0000});
    scan(16'h5678, 8, 1'b1);
    blank(10);
    checkOutput("stale_cleared", {31'h0, stale}, 32'h0);
    checkOutput("pending_t5", exp_q.size(), 0);

    $display("[TB] reset mid-frame then 9E0F scan");
    applyStimulus(4'b1011, seg_of(4'hC), 8);
    applyStimulus(4'b0111, seg_of(4'hD), 8);
    reset = 1'b0;
    #2;
    checkOutput("midreset_value", {16'h0, value}, 32'h0);
    checkOutput("midreset_fv", {31'h0, frame_valid}, 32'h0);
    checkOutput("midreset_err", {28'h0, digit_err}, 32'h0);
    checkOutput("midreset_stale", {31'h0, stale}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    blank(5);
    exp_q.push_back('{16'h9E0F, 4'b0000});
    scan(16'h9E0F, 8, 1'b0);
    blank(10);
    checkOutput("pending_t6", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
